cpu_dp_pipe: RTL
================

# cpu_dp_pipe

Parametrised two-stage successor to the fib CPU datapath: register file, function unit, operand/result muxes and memory port, with generic data width, address width and register count. An operand-fetch register splits the datapath into fetch and execute/write-back stages, with write-back forwarding and a ready/busy memory handshake, so the controller can issue one operation per cycle and stall only on memory wait states. Sits between the control unit (which supplies decoded fields and pc) and the data memory.

## Interface
- BW, 8, data width (≥4)
- AW, 9, memory address width (≤ BW+1; busA zero-extended if BW < AW)
- NREG, 16, register count (power of 2, ≥2); RAW = log2(NREG)
- IMMW, 3, immediate width (≤ BW), zero-extended onto operand B
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- issue  in  1  decoded operation valid this cycle
- da / aa / ba  in  RAW  destination / A-source / B-source register
- mb  in  1  operand B = immediate
- fs  in  5  function select (package codes)
- md  in  1  load: write-back from din
- mw  in  1  store: dout written to memory
- rw  in  1  register write enable
- mm  in  1  address = pc_out
- imm  in  IMMW  immediate
- pc_out  in  AW  program counter
- din  in  BW  memory read data
- mem_rdy  in  1  memory completes pending access
- addr  out  AW  memory address
- dout  out  BW  memory write data
- mem_req / mem_we  out  1  access pending / is store
- busy  out  1  stage 2 stalled; issue ignored
- retire  out  1  stage 2 op completes this cycle
- psw  out  4  {V,C,N,Z}
- r0, r1  out  BW  debug copies of reg 0, reg 1

## Operation
- Stage 1 (on issue && !busy): read A/B, mux immediate onto B, capture opA, opB, fs, da, rw, md, mw, mm, pc_out, ex_valid=1. No issue → ex_valid=0 on edge if stage 2 retires.
- Stage 2: ALU combinational on opA/opB. addr = ex_mm ? ex_pc : opA; dout = opB; mem_req = ex_valid && (md||mw); mem_we = ex_valid && mw.
- Completion: ALU ops retire immediately; memory ops retire on mem_rdy (zero-wait allowed). busy = mem_req && !mem_rdy.
- Write-back at retire edge: if rw, rf[da] ← md ? din : fout. psw updated on retire of non-memory ops only.
- Forwarding: stage 1 read of register X while retiring op writes X gets write-back value.
- fs codes: 0 PASSA, 1 INC, 2 ADD, 5 SUB, 6 DEC, 8 AND, 9 OR, 10 XOR, 11 NOTA, 12 PASSB, 13 SHR, 14 SHL; others → 0, psw unchanged. C = carry-out (borrow-inverted for SUB/DEC; shifted-out bit for shifts), V = signed overflow (add/sub only, else 0), N = MSB, Z = result==0.
- Reset (any time, including mid-access): all registers, psw, ex_valid → 0; pending access dropped, no write-back.

## Timing
- Reset values: addr=0, dout=0, mem_req=0, mem_we=0, busy=0, retire=0, psw=0, r0=r1=0.
- Issue at cycle N → stage 2 in N+1 → result visible in rf (and r0/r1) after edge ending N+1; op issued at N+1 uses it via forwarding.
- Memory op with k wait cycles holds busy for k cycles; issue ignored during busy; controller holds fields.
- Back-to-back ALU ops: throughput 1/cycle, no stall.

## Structure
- Package cpu_dp_pkg: fs code constants, psw bit indices, RAW function.
- Sub-module cpu_alu (combinational, BW-parametrised: fs, a, b → f, v, c, n, z); register file, pipeline register, forwarding and handshake in top.

## Test plan
- Reset mid-load (mem_req=1, mem_rdy=0), deassert → no write, all outputs 0, busy=0.
- Issue INC r1←r0 then ADD r2←r1+r1 back-to-back (r0=5) → r1=6, r2=12, no busy cycle (forwarding).
- BW=8: SUB 0x00−0x01 → 0xFF, psw C=0,N=1,Z=0; ADD 0x7F+0x01 → 0x80, V=1,N=1.
- Load r3 from addr 0x1A, mem_rdy after 2 cycles, din=0xA5 → busy 2 cycles, retire 1 cycle, r3=0xA5, psw unchanged.
- Store with mm=1, pc_out=0x123 → addr=0x123, mem_we=1, no register write.
- Params BW=16, NREG=32: ADD r31←r30+imm 7 (r30=0xFFFB) → 0x0002, C=1.

Source files
------------

// File: rtl/cpu_dp_pkg.sv
// Shared definitions for the pipelined datapath: function-select codes,
// psw bit positions and register-address width helpers.
package cpu_dp_pkg;

    localparam logic [4:0] FS_PASSA = 5'd0;
    localparam logic [4:0] FS_INC   = 5'd1;
    localparam logic [4:0] FS_ADD   = 5'd2;
    localparam logic [4:0] FS_SUB   = 5'd5;
    localparam logic [4:0] FS_DEC   = 5'd6;
    localparam logic [4:0] FS_AND   = 5'd8;
    localparam logic [4:0] FS_OR    = 5'd9;
    localparam logic [4:0] FS_XOR   = 5'd10;
    localparam logic [4:0] FS_NOTA  = 5'd11;
    localparam logic [4:0] FS_PASSB = 5'd12;
    localparam logic [4:0] FS_SHR   = 5'd13;
    localparam logic [4:0] FS_SHL   = 5'd14;

    // psw is packed as {V,C,N,Z}
    localparam int PSW_Z = 0;
    localparam int PSW_N = 1;
    localparam int PSW_C = 2;
    localparam int PSW_V = 3;

    function automatic int raw_w(input int nreg);
        return $clog2(nreg);
    endfunction

    // Undefined codes produce zero and must leave psw untouched.
    function automatic logic fs_valid(input logic [4:0] fs);
        case (fs)
            FS_PASSA, FS_INC, FS_ADD, FS_SUB, FS_DEC, FS_AND, FS_OR,
            FS_XOR, FS_NOTA, FS_PASSB, FS_SHR, FS_SHL: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_dp_pipe_if.sv
// Controller/memory-facing bundle of the pipelined datapath.
// master = controller + data memory side, slave = datapath.
interface cpu_dp_pipe_if
    import cpu_dp_pkg::*;
#(
    parameter int BW   = 8,
    parameter int AW   = 9,
    parameter int NREG = 16,
    parameter int IMMW = 3
) ();
    localparam int RAW = raw_w(NREG);

    logic            issue;
    logic [RAW-1:0]  da, aa, ba;
    logic            mb, md, mw, rw, mm;
    logic [4:0]      fs;
    logic [IMMW-1:0] imm;
    logic [AW-1:0]   pc_out;
    logic [BW-1:0]   din;
    logic            mem_rdy;

    logic [AW-1:0]   addr;
    logic [BW-1:0]   dout;
    logic            mem_req, mem_we, busy, retire;
    logic [3:0]      psw;
    logic [BW-1:0]   r0, r1;

    modport master (
        output issue, da, aa, ba, mb, fs, md, mw, rw, mm, imm, pc_out, din, mem_rdy,
        input  addr, dout, mem_req, mem_we, busy, retire, psw, r0, r1
    );

    modport slave (
        input  issue, da, aa, ba, mb, fs, md, mw, rw, mm, imm, pc_out, din, mem_rdy,
        output addr, dout, mem_req, mem_we, busy, retire, psw, r0, r1
    );

endinterface

// File: rtl/cpu_alu.sv
// Combinational function unit with V/C/N/Z generation.
// Latency: zero cycles. Backpressure: none (pure logic).
// C is carry-out (inverted borrow on SUB/DEC, shifted-out bit on shifts).
module cpu_alu
    import cpu_dp_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic [4:0]    fs,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [BW-1:0] f,
    output logic          v,
    output logic          c,
    output logic          n,
    output logic          z
);
    localparam int MSB = BW - 1;

    logic [BW:0] sum;

    always_comb begin
        sum = '0;
        f   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (fs)
            FS_PASSA: f = a;
            FS_INC: begin
                sum = {1'b0, a} + (BW+1)'(1);
                f   = sum[MSB:0];
                c   = sum[BW];
                v   = ~a[MSB] & f[MSB];
            end
            FS_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                f   = sum[MSB:0];
                c   = sum[BW];
                v   = (a[MSB] == b[MSB]) && (f[MSB] != a[MSB]);
            end
            FS_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + (BW+1)'(1);
                f   = sum[MSB:0];
                c   = sum[BW];
                v   = (a[MSB] != b[MSB]) && (f[MSB] != a[MSB]);
            end
            FS_DEC: begin
                sum = {1'b0, a} + {1'b0, {BW{1'b1}}};
                f   = sum[MSB:0];
                c   = sum[BW];
                v   = a[MSB] & ~f[MSB];
            end
            FS_AND:   f = a & b;
            FS_OR:    f = a | b;
            FS_XOR:   f = a ^ b;
            FS_NOTA:  f = ~a;
            FS_PASSB: f = b;
            FS_SHR: begin
                f = {1'b0, a[MSB:1]};
                c = a[0];
            end
            FS_SHL: begin
                f = {a[MSB-1:0], 1'b0};
                c = a[MSB];
            end
            default: f = '0;
        endcase
    end

    assign n = f[MSB];
    assign z = (f == '0);

endmodule

// File: rtl/cpu_dp_pipe.sv
// Two-stage datapath: operand fetch into a pipeline register, then ALU/memory + write-back.
// Latency: result in register file one edge after the op leaves fetch; forwarded to the next op.
// Backpressure: busy while a memory access waits for mem_rdy; issue is ignored while busy.
module cpu_dp_pipe
    import cpu_dp_pkg::*;
#(
    parameter int BW   = 8,
    parameter int AW   = 9,
    parameter int NREG = 16,
    parameter int IMMW = 3
) (
    input logic          clk,
    input logic          rst,
    cpu_dp_pipe_if.slave bus
);
    localparam int RAW = raw_w(NREG);

    logic [BW-1:0]  rf [NREG];
    logic           ex_valid, ex_rw, ex_md, ex_mw, ex_mm;
    logic [4:0]     ex_fs;
    logic [RAW-1:0] ex_da;
    logic [AW-1:0]  ex_pc;
    logic [BW-1:0]  op_a, op_b;
    logic [3:0]     psw;

    logic [BW-1:0]  fout, wb_val, rd_a, rd_b;
    logic           fv, fc, fn, fz;
    logic           is_mem, mem_req, busy, retire, wb_en;

    cpu_alu #(.BW(BW)) u_alu (
        .fs (ex_fs),
        .a  (op_a),
        .b  (op_b),
        .f  (fout),
        .v  (fv),
        .c  (fc),
        .n  (fn),
        .z  (fz)
    );

    assign is_mem  = ex_md | ex_mw;
    assign mem_req = ex_valid & is_mem;
    assign busy    = mem_req & ~bus.mem_rdy;
    assign retire  = ex_valid & ~busy;
    assign wb_val  = ex_md ? bus.din : fout;
    assign wb_en   = retire & ex_rw;

    // The retiring op's write is not in rf yet, so fetch bypasses it.
    assign rd_a = (wb_en && ex_da == bus.aa) ? wb_val : rf[bus.aa];
    assign rd_b = (wb_en && ex_da == bus.ba) ? wb_val : rf[bus.ba];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            psw      <= '0;
            ex_valid <= 1'b0;
            ex_rw    <= 1'b0;
            ex_md    <= 1'b0;
            ex_mw    <= 1'b0;
            ex_mm    <= 1'b0;
            ex_fs    <= '0;
            ex_da    <= '0;
            ex_pc    <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            if (wb_en) rf[ex_da] <= wb_val;
            if (retire && !is_mem && fs_valid(ex_fs)) begin
                psw[PSW_V] <= fv;
                psw[PSW_C] <= fc;
                psw[PSW_N] <= fn;
                psw[PSW_Z] <= fz;
            end
            if (!busy) begin
                ex_valid <= bus.issue;
                if (bus.issue) begin
                    op_a  <= rd_a;
                    op_b  <= bus.mb ? BW'(bus.imm) : rd_b;
                    ex_fs <= bus.fs;
                    ex_da <= bus.da;
                    ex_rw <= bus.rw;
                    ex_md <= bus.md;
                    ex_mw <= bus.mw;
                    ex_mm <= bus.mm;
                    ex_pc <= bus.pc_out;
                end
            end
        end
    end

    assign bus.addr    = ex_mm ? ex_pc : AW'(op_a);
    assign bus.dout    = op_b;
    assign bus.mem_req = mem_req;
    assign bus.mem_we  = ex_valid & ex_mw;
    assign bus.busy    = busy;
    assign bus.retire  = retire;
    assign bus.psw     = psw;
    assign bus.r0      = rf[0];
    assign bus.r1      = rf[1];

endmodule
